// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, flag bit
// positions and small helpers used by both the combinational core and the
// iterative top level.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'h0,
      OP_OR  = 4'h1,
      OP_ADD = 4'h2,
      OP_INC = 4'h3,
      OP_DEC = 4'h4,
      OP_NOT = 4'h5,
      OP_SUB = 4'h6,
      OP_XOR = 4'h7,
      OP_SHL = 4'h8,
      OP_SHR = 4'h9,
      OP_MUL = 4'hA,
      OP_ROL = 4'hB
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } alu_state_t;

   // Bit positions inside ALUFlags = {Negativo, Overflow, Carry, Cero}
   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_N = 3;

   // Opcodes that run through the multi-cycle EXEC state
   function automatic logic is_iter_op(input logic [3:0] op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_MUL) || (op == OP_ROL);
   endfunction

   // Assemble the 4-bit flag vector from its individual bits
   function automatic logic [3:0] pack_flags(input logic neg, input logic ovf,
                                             input logic cy, input logic zero);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_N] = neg;
      f[FLAG_V] = ovf;
      f[FLAG_C] = cy;
      f[FLAG_Z] = zero;
      return f;
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations (opcodes 0-7) and their flags. Any other
// opcode yields result 0 with only Cero set, which is exactly the
// illegal-opcode response; the top ignores this output for iterative ops.
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         flag_i,
   input  logic [3:0]   op_i,
   output logic [N-1:0] result_o,
   output logic [3:0]   flags_o
);

   localparam logic [N-1:0] ZERO_N  = {N{1'b0}};
   localparam logic [N-1:0] ONE_N   = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

   logic [N:0]   sum_s;
   logic [N:0]   diff_s;
   logic [N-1:0] sel_s;
   logic [N-1:0] res_s;
   logic         cy_s;
   logic         ovf_s;

   // Opcode decode: result, carry/borrow and signed overflow
   always_comb begin
      sum_s  = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, flag_i};
      diff_s = {1'b0, a_i} - {1'b0, b_i} - {{N{1'b0}}, flag_i};
      if (flag_i) begin
         sel_s = b_i;
      end else begin
         sel_s = a_i;
      end
      res_s = ZERO_N;
      cy_s  = 1'b0;
      ovf_s = 1'b0;
      case (op_i)
         OP_AND: res_s = a_i & b_i;
         OP_OR:  res_s = a_i | b_i;
         OP_XOR: res_s = a_i ^ b_i;
         OP_NOT: res_s = ~sel_s;
         OP_ADD: begin
            res_s = sum_s[N-1:0];
            cy_s  = sum_s[N];
            ovf_s = (a_i[N-1] == b_i[N-1]) && (res_s[N-1] != a_i[N-1]);
         end
         OP_SUB: begin
            // Bit N of the widened difference is the borrow
            res_s = diff_s[N-1:0];
            cy_s  = diff_s[N];
            ovf_s = (a_i[N-1] != b_i[N-1]) && (res_s[N-1] != a_i[N-1]);
         end
         OP_INC: begin
            res_s = sel_s + ONE_N;
            cy_s  = (sel_s == {N{1'b1}});
            ovf_s = (sel_s == MAX_POS);
         end
         OP_DEC: begin
            res_s = sel_s - ONE_N;
            cy_s  = (sel_s == ZERO_N);
            ovf_s = (sel_s == MIN_NEG);
         end
         default: begin
            res_s = ZERO_N;
            cy_s  = 1'b0;
            ovf_s = 1'b0;
         end
      endcase
      result_o = res_s;
      flags_o  = pack_flags(res_s[N-1], ovf_s, cy_s, res_s == ZERO_N);
   end

endmodule

// File: rtl/module_alu_seq.sv
// Sequential ALU: single-cycle ops come from alu_comb_core; shifts, rotate
// and the shift-and-add multiplier iterate one step per cycle in EXEC.
// Visible results only update when the FSM enters DONE.
module module_alu_seq
   import alu_pkg::*;
#(
   parameter int N     = 8,
   parameter int CNT_W = $clog2(N + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] ALUA,
   input  logic [N-1:0] ALUB,
   input  logic         ALUFlagIn,
   input  logic [3:0]   ALUControl,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] ALUResult,
   output logic [N-1:0] ALUResultHi,
   output logic [3:0]   ALUFlags
);

   localparam logic [N-1:0]     ZERO_N  = {N{1'b0}};
   localparam logic [N-1:0]     N_VEC   = N'(N);
   localparam logic [CNT_W-1:0] CNT_0   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_1   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_N   = CNT_W'(N);

   alu_state_t       state_q, state_d;
   logic [3:0]       op_q;
   logic             fill_q;
   logic [CNT_W-1:0] cnt_q;
   logic [N-1:0]     work_lo_q;
   logic [N-1:0]     work_hi_q;
   logic [N-1:0]     mcand_q;
   logic             carry_q;
   logic [N-1:0]     result_q;
   logic [N-1:0]     result_hi_q;
   logic [3:0]       flags_q;

   logic [N-1:0]     core_res_s;
   logic [3:0]       core_flags_s;
   logic [CNT_W-1:0] k_s;
   logic [N:0]       mul_sum_s;
   logic [N-1:0]     step_lo_s;
   logic [N-1:0]     step_hi_s;
   logic             step_c_s;
   logic [N-1:0]     iter_res_s;
   logic [N-1:0]     iter_hi_s;
   logic [3:0]       iter_flags_s;

   alu_comb_core #(.N(N)) u_core (
      .a_i      (ALUA),
      .b_i      (ALUB),
      .flag_i   (ALUFlagIn),
      .op_i     (ALUControl),
      .result_o (core_res_s),
      .flags_o  (core_flags_s)
   );

   // Iteration count for the requested op: shifts saturate at N, rotate wraps
   always_comb begin
      k_s = CNT_0;
      case (ALUControl)
         OP_SHL, OP_SHR: begin
            if (ALUB >= N_VEC) begin
               k_s = CNT_N;
            end else begin
               k_s = CNT_W'(ALUB);
            end
         end
         OP_ROL:  k_s = CNT_W'(ALUB % N_VEC);
         OP_MUL:  k_s = CNT_N;
         default: k_s = CNT_0;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (is_iter_op(ALUControl) && (k_s != CNT_0)) begin
                  state_d = ST_EXEC;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (cnt_q == CNT_1) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: busy covers EXEC and DONE, done pulses for the one DONE cycle
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         ST_EXEC: busy = 1'b1;
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // One iteration step of the captured shift/rotate/multiply
   always_comb begin
      mul_sum_s = {(N+1){1'b0}};
      step_lo_s = work_lo_q;
      step_hi_s = work_hi_q;
      step_c_s  = carry_q;
      case (op_q)
         OP_SHL: {step_c_s, step_lo_s} = {work_lo_q, fill_q};
         OP_SHR: {step_lo_s, step_c_s} = {fill_q, work_lo_q};
         OP_ROL: begin
            step_lo_s = {work_lo_q[N-2:0], work_lo_q[N-1]};
            step_c_s  = work_lo_q[N-1];
         end
         OP_MUL: begin
            // Add multiplicand when the multiplier LSB is set, then shift {hi,lo} right
            if (work_lo_q[0]) begin
               mul_sum_s = {1'b0, work_hi_q} + {1'b0, mcand_q};
            end else begin
               mul_sum_s = {1'b0, work_hi_q};
            end
            step_hi_s = mul_sum_s[N:1];
            step_lo_s = {mul_sum_s[0], work_lo_q[N-1:1]};
            step_c_s  = 1'b0;
         end
         default: begin
            step_lo_s = work_lo_q;
            step_hi_s = work_hi_q;
            step_c_s  = carry_q;
         end
      endcase
   end

   // Final-step results and flags for iterative ops
   always_comb begin
      if (op_q == OP_MUL) begin
         iter_res_s   = step_lo_s;
         iter_hi_s    = step_hi_s;
         iter_flags_s = pack_flags(step_hi_s[N-1], 1'b0, 1'b0,
                                   {step_hi_s, step_lo_s} == {(2*N){1'b0}});
      end else begin
         iter_res_s   = step_lo_s;
         iter_hi_s    = ZERO_N;
         iter_flags_s = pack_flags(step_lo_s[N-1], 1'b0, step_c_s, step_lo_s == ZERO_N);
      end
   end

   // Operand capture, iteration datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q        <= 4'h0;
         fill_q      <= 1'b0;
         cnt_q       <= CNT_0;
         work_lo_q   <= ZERO_N;
         work_hi_q   <= ZERO_N;
         mcand_q     <= ZERO_N;
         carry_q     <= 1'b0;
         result_q    <= ZERO_N;
         result_hi_q <= ZERO_N;
         flags_q     <= 4'b0000;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  op_q      <= ALUControl;
                  fill_q    <= ALUFlagIn;
                  cnt_q     <= k_s;
                  mcand_q   <= ALUA;
                  carry_q   <= 1'b0;
                  work_hi_q <= ZERO_N;
                  if (ALUControl == OP_MUL) begin
                     work_lo_q <= ALUB;
                  end else begin
                     work_lo_q <= ALUA;
                  end
                  if (!is_iter_op(ALUControl)) begin
                     result_q    <= core_res_s;
                     result_hi_q <= ZERO_N;
                     flags_q     <= core_flags_s;
                  end else if (k_s == CNT_0) begin
                     // Zero-length shift/rotate passes A through with no carry
                     result_q    <= ALUA;
                     result_hi_q <= ZERO_N;
                     flags_q     <= pack_flags(ALUA[N-1], 1'b0, 1'b0, ALUA == ZERO_N);
                  end
               end
            end
            ST_EXEC: begin
               work_lo_q <= step_lo_s;
               work_hi_q <= step_hi_s;
               carry_q   <= step_c_s;
               cnt_q     <= cnt_q - CNT_1;
               if (cnt_q == CNT_1) begin
                  result_q    <= iter_res_s;
                  result_hi_q <= iter_hi_s;
                  flags_q     <= iter_flags_s;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign ALUResult   = result_q;
   assign ALUResultHi = result_hi_q;
   assign ALUFlags    = flags_q;

endmodule

// File: tb/tb_module_alu_seq.sv
// Directed-vector bench for module_alu_seq (N=8). Stimulus pushes the
// hand-computed expectation into a queue; a monitor pops and compares on
// every done pulse, including the done latency in cycles.
module tb_module_alu_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] ALUA = 8'h00;
   logic [7:0] ALUB = 8'h00;
   logic       ALUFlagIn = 1'b0;
   logic [3:0] ALUControl = 4'h0;
   logic       busy;
   logic       done;
   logic [7:0] ALUResult;
   logic [7:0] ALUResultHi;
   logic [3:0] ALUFlags;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] res;
      logic [7:0] hi;
      logic [3:0] fl;
      int         lat;
      int         issued;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   module_alu_seq #(.N(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .ALUA        (ALUA),
      .ALUB        (ALUB),
      .ALUFlagIn   (ALUFlagIn),
      .ALUControl  (ALUControl),
      .busy        (busy),
      .done        (done),
      .ALUResult   (ALUResult),
      .ALUResultHi (ALUResultHi),
      .ALUFlags    (ALUFlags)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every done pulse must match the oldest expectation
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending op", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, ".result"}, {8'h00, ALUResult}, {8'h00, mon_e.res});
            check({mon_e.name, ".hi"}, {8'h00, ALUResultHi}, {8'h00, mon_e.hi});
            check({mon_e.name, ".flags"}, {12'h000, ALUFlags}, {12'h000, mon_e.fl});
            check({mon_e.name, ".latency"}, 16'(cyc - mon_e.issued), 16'(mon_e.lat));
         end
      end
   end

   task automatic issue(input string name, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic fin, input logic [7:0] res,
                        input logic [7:0] hi, input logic [3:0] fl, input int lat);
      exp_t e;
      int   w;
      @(negedge clk);
      w = 0;
      while (busy === 1'b1 && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (w >= 40) begin
         n_vec++;
         n_err++;
         $display("FAIL %s.busy_wait: busy still 1 after 40 cycles, expected 0", name);
      end
      ALUControl = op;
      ALUA       = a;
      ALUB       = b;
      ALUFlagIn  = fin;
      start      = 1'b1;
      e.res = res; e.hi = hi; e.fl = fl; e.lat = lat; e.issued = cyc; e.name = name;
      exp_q.push_back(e);
      @(negedge clk);
      // Scramble inputs while the op is in flight
      start      = 1'b0;
      ALUA       = ~a;
      ALUB       = ~b;
      ALUFlagIn  = ~fin;
      ALUControl = ~op;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d ops without done after 40 cycles, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset.busy", {15'h0, busy}, 16'h0000);
      check("reset.done", {15'h0, done}, 16'h0000);
      check("reset.result", {8'h00, ALUResult}, 16'h0000);
      check("reset.hi", {8'h00, ALUResultHi}, 16'h0000);
      check("reset.flags", {12'h000, ALUFlags}, 16'h0000);
      rst = 1'b0;

      //     name          op     A      B      fin   res    hi     flags    lat
      issue("add_ff_01",   4'h2, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 4'b0011, 1);
      issue("sub_80_01",   4'h6, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 4'b0100, 1);
      issue("shl_81_3",    4'h8, 8'h81, 8'h03, 1'b1, 8'h0F, 8'h00, 4'b0000, 4);
      issue("shl_81_0",    4'h8, 8'h81, 8'h00, 1'b1, 8'h81, 8'h00, 4'b1000, 1);
      issue("illegal_e",   4'hE, 8'hFF, 8'hFF, 1'b1, 8'h00, 8'h00, 4'b0001, 1);
      issue("illegal_f",   4'hF, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 4'b0001, 1);
      issue("and",         4'h0, 8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00, 4'b0000, 1);
      issue("or",          4'h1, 8'h0F, 8'h80, 1'b1, 8'h8F, 8'h00, 4'b1000, 1);
      issue("xor",         4'h7, 8'hAA, 8'hAA, 1'b0, 8'h00, 8'h00, 4'b0001, 1);
      issue("inc_a_7f",    4'h3, 8'h7F, 8'h00, 1'b0, 8'h80, 8'h00, 4'b1100, 1);
      issue("inc_b_ff",    4'h3, 8'h01, 8'hFF, 1'b1, 8'h00, 8'h00, 4'b0011, 1);
      issue("dec_a_80",    4'h4, 8'h80, 8'h00, 1'b0, 8'h7F, 8'h00, 4'b0100, 1);
      issue("dec_b_00",    4'h4, 8'h05, 8'h00, 1'b1, 8'hFF, 8'h00, 4'b1010, 1);
      issue("not_b",       4'h5, 8'h00, 8'h0F, 1'b1, 8'hF0, 8'h00, 4'b1000, 1);
      issue("add_cin",     4'h2, 8'h7F, 8'h00, 1'b1, 8'h80, 8'h00, 4'b1100, 1);
      issue("sub_bin",     4'h6, 8'h05, 8'h05, 1'b1, 8'hFF, 8'h00, 4'b1010, 1);
      issue("shr_81_1",    4'h9, 8'h81, 8'h01, 1'b0, 8'h40, 8'h00, 4'b0010, 2);
      issue("shr_81_sat",  4'h9, 8'h81, 8'h20, 1'b1, 8'hFF, 8'h00, 4'b1010, 9);
      issue("shl_01_8",    4'h8, 8'h01, 8'h08, 1'b0, 8'h00, 8'h00, 4'b0011, 9);
      issue("rol_81_9",    4'hB, 8'h81, 8'h09, 1'b0, 8'h03, 8'h00, 4'b0010, 2);
      issue("rol_81_8",    4'hB, 8'h81, 8'h08, 1'b1, 8'h81, 8'h00, 4'b1000, 1);
      issue("mul_00_05",   4'hA, 8'h00, 8'h05, 1'b0, 8'h00, 8'h00, 4'b0001, 9);
      issue("mul_10_10",   4'hA, 8'h10, 8'h10, 1'b0, 8'h00, 8'h01, 4'b0000, 9);
      issue("mul_ff_ff",   4'hA, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 4'b1000, 9);
      drain();

      // Abort a multiply with reset; start pulses during busy/reset are ignored
      ALUControl = 4'hA; ALUA = 8'h33; ALUB = 8'h44; ALUFlagIn = 1'b0;
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); start = 1'b1; ALUA = 8'h12;
      check("abort.busy_mid", {15'h0, busy}, 16'h0001);
      @(negedge clk); start = 1'b0;
      @(negedge clk); rst = 1'b1; start = 1'b1;
      @(negedge clk);
      check("abort.busy", {15'h0, busy}, 16'h0000);
      check("abort.done", {15'h0, done}, 16'h0000);
      check("abort.result", {8'h00, ALUResult}, 16'h0000);
      check("abort.hi", {8'h00, ALUResultHi}, 16'h0000);
      check("abort.flags", {12'h000, ALUFlags}, 16'h0000);
      rst = 1'b0; start = 1'b0;

      issue("post_reset_add", 4'h2, 8'h01, 8'h02, 1'b0, 8'h03, 8'h00, 4'b0000, 1);
      drain();
      repeat (12) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
